// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequencing controller for a SIZE-bit accumulating adder.
// Takes a run of `count` operands over a valid/ready stream, adds them into
// SUM one per cycle, applies CI to the first addition only, and keeps CO as a
// sticky overflow flag for the whole run.
module adder_seq_ctrl #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             CI,
  input  logic             abort,
  input  logic [SIZE-1:0]  op_data,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [SIZE-1:0]  SUM,
  output logic             CO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  sum_q, sum_d;
  logic             co_q, co_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             carry_pending_q, carry_pending_d;

  logic             handshake;
  logic [SIZE:0]    add_full;

  // The adder sees the pending carry-in only on the first addition of a run;
  // the extra top bit is the carry-out of this addition.
  assign add_full  = {1'b0, sum_q} + {1'b0, op_data} + {{SIZE{1'b0}}, carry_pending_q};
  // op_ready is decoded from state, so a handshake can only happen in ACC.
  assign handshake = op_valid && op_ready;

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q         <= IDLE;
      sum_q           <= '0;
      co_q            <= 1'b0;
      remaining_q     <= '0;
      carry_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sum_q           <= sum_d;
      co_q            <= co_d;
      remaining_q     <= remaining_d;
      carry_pending_q <= carry_pending_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    sum_d           = sum_q;
    co_d            = co_q;
    remaining_d     = remaining_q;
    carry_pending_d = carry_pending_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sum_d = '0;
          co_d  = 1'b0;
          if (count != '0) begin
            remaining_d     = count;
            carry_pending_d = CI;
            state_d         = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end

      ACC: begin
        if (abort) begin
          // Abort beats a same-cycle handshake; the operand is not consumed.
          sum_d   = '0;
          co_d    = 1'b0;
          state_d = IDLE;
        end else if (handshake) begin
          sum_d           = add_full[SIZE-1:0];
          co_d            = co_q | add_full[SIZE];
          carry_pending_d = 1'b0;
          remaining_d     = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    op_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ACC: begin
        op_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign SUM = sum_q;
  assign CO  = co_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl (SIZE=16, CNT_W=8).
module tb_adder_seq_ctrl;

  localparam int SIZE  = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             CI;
  logic             abort;
  logic [SIZE-1:0]  op_data;
  logic             op_valid;
  logic             op_ready;
  logic             busy;
  logic             done;
  logic [SIZE-1:0]  SUM;
  logic             CO;

  int n_checks = 0;
  int n_fails  = 0;

  adder_seq_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .CI       (CI),
    .abort    (abort),
    .op_data  (op_data),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .SUM      (SUM),
    .CO       (CO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_flags(input string tag, input logic rdy, input logic bsy, input logic dn);
    check({tag, ".op_ready"}, 32'(op_ready), 32'(rdy));
    check({tag, ".busy"},     32'(busy),     32'(bsy));
    check({tag, ".done"},     32'(done),     32'(dn));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; CI = 1'b0; abort = 1'b0;
    op_data = '0; op_valid = 1'b0;
    tick();
    tick();
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset.SUM", 32'(SUM), 32'h0);
    check("reset.CO",  32'(CO),  32'h0);
    rst = 1'b0;

    // Basic run: 3 + 16 = 19.
    start = 1'b1; count = 8'd2; CI = 1'b0;
    tick();
    start = 1'b0;
    check_flags("basic.acc", 1'b1, 1'b1, 1'b0);
    check("basic.sum0", 32'(SUM), 32'd0);
    op_valid = 1'b1; op_data = 16'd3;
    tick();
    check("basic.sum1", 32'(SUM), 32'd3);
    op_data = 16'd16;
    tick();
    op_valid = 1'b0;
    check("basic.sum2", 32'(SUM), 32'd19);
    check("basic.co",   32'(CO),  32'd0);
    check_flags("basic.done", 1'b0, 1'b0, 1'b1);
    tick();
    check_flags("basic.idle", 1'b0, 1'b0, 1'b0);
    check("basic.hold", 32'(SUM), 32'd19);

    // Carry-in applied once: 16 + 104 + 1 = 121.
    start = 1'b1; count = 8'd2; CI = 1'b1;
    tick();
    start = 1'b0; CI = 1'b0;
    op_valid = 1'b1; op_data = 16'd16;
    tick();
    check("ci.sum1", 32'(SUM), 32'd17);
    op_data = 16'd104;
    tick();
    op_valid = 1'b0;
    check("ci.sum2", 32'(SUM), 32'd121);
    check("ci.co",   32'(CO),  32'd0);
    check("ci.done", 32'(done), 32'd1);
    tick();

    // Sticky overflow: FFFF + 2 wraps to 1 with carry, + 1 = 2, CO stays.
    start = 1'b1; count = 8'd3; CI = 1'b0;
    tick();
    start = 1'b0;
    op_valid = 1'b1; op_data = 16'hFFFF;
    tick();
    check("ovf.sum1", 32'(SUM), 32'hFFFF);
    check("ovf.co1",  32'(CO),  32'd0);
    op_data = 16'h0002;
    tick();
    check("ovf.sum2", 32'(SUM), 32'h0001);
    check("ovf.co2",  32'(CO),  32'd1);
    op_data = 16'h0001;
    tick();
    op_valid = 1'b0;
    check("ovf.sum3", 32'(SUM), 32'h0002);
    check("ovf.co3",  32'(CO),  32'd1);
    check("ovf.done", 32'(done), 32'd1);
    tick();
    check("ovf.hold_co", 32'(CO), 32'd1);

    // Zero count: straight to DONE, result cleared, never ready.
    start = 1'b1; count = 8'd0; CI = 1'b1;
    tick();
    start = 1'b0; CI = 1'b0;
    check_flags("zero.done", 1'b0, 1'b0, 1'b1);
    check("zero.sum", 32'(SUM), 32'd0);
    check("zero.co",  32'(CO),  32'd0);
    tick();
    check_flags("zero.idle", 1'b0, 1'b0, 1'b0);

    // Backpressure: 30, three idle cycles, then 5.
    start = 1'b1; count = 8'd2;
    tick();
    start = 1'b0;
    op_valid = 1'b1; op_data = 16'd30;
    tick();
    check("bp.sum1", 32'(SUM), 32'd30);
    op_valid = 1'b0; op_data = 16'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.gap_sum",  32'(SUM),  32'd30);
      check("bp.gap_busy", 32'(busy), 32'd1);
    end
    op_valid = 1'b1; op_data = 16'd5;
    tick();
    op_valid = 1'b0;
    check("bp.sum2", 32'(SUM), 32'd35);
    check("bp.done", 32'(done), 32'd1);
    tick();

    // Abort wins over a same-cycle handshake.
    start = 1'b1; count = 8'd4;
    tick();
    start = 1'b0;
    op_valid = 1'b1; op_data = 16'd7;
    tick();
    check("abort.sum1", 32'(SUM), 32'd7);
    abort = 1'b1; op_data = 16'd9;
    tick();
    abort = 1'b0; op_valid = 1'b0;
    check_flags("abort.idle", 1'b0, 1'b0, 1'b0);
    check("abort.sum", 32'(SUM), 32'd0);
    check("abort.co",  32'(CO),  32'd0);
    tick();
    check("abort.no_done", 32'(done), 32'd0);
    start = 1'b1; count = 8'd1; CI = 1'b1;
    tick();
    start = 1'b0; CI = 1'b0;
    check("abort.restart_busy", 32'(busy), 32'd1);
    op_valid = 1'b1; op_data = 16'h0010;
    tick();
    op_valid = 1'b0;
    check("abort.restart_sum",  32'(SUM),  32'h0011);
    check("abort.restart_done", 32'(done), 32'd1);
    tick();

    // Reset in the middle of a run.
    start = 1'b1; count = 8'd3;
    tick();
    start = 1'b0;
    op_valid = 1'b1; op_data = 16'h00AB;
    tick();
    op_valid = 1'b0;
    check("rstmid.sum_pre", 32'(SUM), 32'h00AB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_flags("rstmid", 1'b0, 1'b0, 1'b0);
    check("rstmid.sum", 32'(SUM), 32'd0);
    check("rstmid.co",  32'(CO),  32'd0);
    tick();
    check("rstmid.still_idle", 32'(busy), 32'd0);

    // start pulsed during ACC must not reload count or clear SUM.
    start = 1'b1; count = 8'd3; CI = 1'b0;
    tick();
    start = 1'b0;
    op_valid = 1'b1; op_data = 16'd1;
    tick();
    op_valid = 1'b0;
    start = 1'b1; count = 8'd1; CI = 1'b1;
    tick();
    start = 1'b0; CI = 1'b0;
    check("sib.sum_kept", 32'(SUM),  32'd1);
    check("sib.busy",     32'(busy), 32'd1);
    op_valid = 1'b1; op_data = 16'd2;
    tick();
    check("sib.sum2",       32'(SUM),  32'd3);
    check("sib.not_done",   32'(done), 32'd0);
    op_data = 16'd4;
    tick();
    op_valid = 1'b0;
    check("sib.sum3", 32'(SUM),  32'd7);
    check("sib.done", 32'(done), 32'd1);
    tick();

    // abort outside ACC has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort.sum", 32'(SUM), 32'd7);
    check_flags("idle_abort", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
